// File: rtl/mini_risc_pkg.sv
// Shared MINI-RISC pipeline types: opcode/reg-id widths, forwarding selects, control bundle.
// Pure declarations; no timing or flow-control behaviour of its own.
package mini_risc_pkg;

  localparam int OPC_W    = 5;
  localparam int REG_ID_W = 3;

  localparam logic [OPC_W-1:0] NOP_OPC = 5'b0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } de_ctrl_t;

  // True when the writeback port is writing the register named by src.
  function automatic logic wb_hit(input logic                we,
                                  input logic [REG_ID_W-1:0] rd_w,
                                  input logic [REG_ID_W-1:0] src);
    return we && (rd_w == src);
  endfunction

endpackage

// File: rtl/de_fwd_mux.sv
// Operand forwarding mux: picks the writeback value on FWD_WB, else the registered operand.
// Purely combinational, zero latency, no flow control.
module de_fwd_mux
  import mini_risc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] wb_val,
  output logic [DATA_W-1:0] op_val
);

  // Reserved encodings 2'b01/2'b11 fall through to the registered operand.
  assign op_val = (sel == FWD_WB) ? wb_val : reg_val;

endmodule

// File: rtl/de_pipe_reg.sv
// Decode->Execute register, 1-cycle latency; stall_D holds (with WB refresh), flush_D inserts a bubble.
// Optional DE_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt outputs.
module de_pipe_reg
  import mini_risc_pkg::*;
#(
  parameter int               DATA_W = 16,
  parameter logic [OPC_W-1:0] NOP_OP = NOP_OPC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_D,
  input  logic                flush_D,
  input  logic [1:0]          forward_A,
  input  logic [1:0]          forward_B,
  input  logic                valid_D,
  input  logic [OPC_W-1:0]    opcode_D,
  input  logic [REG_ID_W-1:0] rd_D,
  input  logic [REG_ID_W-1:0] source_reg1_D,
  input  logic [REG_ID_W-1:0] source_reg2_D,
  input  logic [DATA_W-1:0]   rs1_data_D,
  input  logic [DATA_W-1:0]   rs2_data_D,
  input  logic [DATA_W-1:0]   imm_D,
  input  logic                reg_write_D,
  input  logic                mem_read_D,
  input  logic                mem_write_D,
  input  logic [REG_ID_W-1:0] rd_W,
  input  logic                reg_write_W,
  input  logic [DATA_W-1:0]   result_W,
  output logic                valid_E,
  output logic [OPC_W-1:0]    opcode_E,
  output logic [REG_ID_W-1:0] rd_E,
  output logic [REG_ID_W-1:0] source_reg1_E,
  output logic [REG_ID_W-1:0] source_reg2_E,
  output logic                reg_write_E,
  output logic                mem_read_E,
  output logic                mem_write_E,
  output logic [DATA_W-1:0]   imm_E,
  output logic [DATA_W-1:0]   op_a_E,
  output logic [DATA_W-1:0]   op_b_E
`ifdef DE_PERF_CNT_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         bubble_cnt
`endif
);

  de_ctrl_t          ctrl_d;
  de_ctrl_t          ctrl_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  assign ctrl_d      = '{reg_write: reg_write_D, mem_read: mem_read_D, mem_write: mem_write_D};
  assign reg_write_E = ctrl_q.reg_write;
  assign mem_read_E  = ctrl_q.mem_read;
  assign mem_write_E = ctrl_q.mem_write;

  // Flush wins over stall; operands and immediate are left alone in a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_E       <= 1'b0;
      opcode_E      <= NOP_OP;
      rd_E          <= '0;
      source_reg1_E <= '0;
      source_reg2_E <= '0;
      ctrl_q        <= '0;
      imm_E         <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else if (flush_D) begin
      valid_E       <= 1'b0;
      opcode_E      <= NOP_OP;
      rd_E          <= '0;
      source_reg1_E <= '0;
      source_reg2_E <= '0;
      ctrl_q        <= '0;
    end else if (stall_D) begin
      // A held instruction picks up writebacks to its sources so it never reads stale data.
      if (valid_E && wb_hit(reg_write_W, rd_W, source_reg1_E)) a_q <= result_W;
      if (valid_E && wb_hit(reg_write_W, rd_W, source_reg2_E)) b_q <= result_W;
    end else begin
      valid_E       <= valid_D;
      opcode_E      <= opcode_D;
      rd_E          <= rd_D;
      source_reg1_E <= source_reg1_D;
      source_reg2_E <= source_reg2_D;
      ctrl_q        <= ctrl_d;
      imm_E         <= imm_D;
      a_q           <= wb_hit(reg_write_W, rd_W, source_reg1_D) ? result_W : rs1_data_D;
      b_q           <= wb_hit(reg_write_W, rd_W, source_reg2_D) ? result_W : rs2_data_D;
    end
  end

  de_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .sel     (forward_A),
    .reg_val (a_q),
    .wb_val  (result_W),
    .op_val  (op_a_E)
  );

  de_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .sel     (forward_B),
    .reg_val (b_q),
    .wb_val  (result_W),
    .op_val  (op_b_E)
  );

`ifdef DE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_D && !flush_D && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_D && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed-vector bench for de_pipe_reg: reset, load, bubble, hold/refresh, forwarding, load bypass.
// Counter checks are compiled only when DE_PERF_CNT_EN is defined.
module tb_de_pipe_reg;
  import mini_risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_D, flush_D;
  logic [1:0]  forward_A, forward_B;
  logic        valid_D;
  logic [4:0]  opcode_D;
  logic [2:0]  rd_D, source_reg1_D, source_reg2_D;
  logic [15:0] rs1_data_D, rs2_data_D, imm_D;
  logic        reg_write_D, mem_read_D, mem_write_D;
  logic [2:0]  rd_W;
  logic        reg_write_W;
  logic [15:0] result_W;
  logic        valid_E;
  logic [4:0]  opcode_E;
  logic [2:0]  rd_E, source_reg1_E, source_reg2_E;
  logic        reg_write_E, mem_read_E, mem_write_E;
  logic [15:0] imm_E, op_a_E, op_b_E;
`ifdef DE_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  de_pipe_reg #(.DATA_W(16), .NOP_OP(5'b0)) dut (
    .clk(clk), .rst(rst), .stall_D(stall_D), .flush_D(flush_D),
    .forward_A(forward_A), .forward_B(forward_B),
    .valid_D(valid_D), .opcode_D(opcode_D), .rd_D(rd_D),
    .source_reg1_D(source_reg1_D), .source_reg2_D(source_reg2_D),
    .rs1_data_D(rs1_data_D), .rs2_data_D(rs2_data_D), .imm_D(imm_D),
    .reg_write_D(reg_write_D), .mem_read_D(mem_read_D), .mem_write_D(mem_write_D),
    .rd_W(rd_W), .reg_write_W(reg_write_W), .result_W(result_W),
    .valid_E(valid_E), .opcode_E(opcode_E), .rd_E(rd_E),
    .source_reg1_E(source_reg1_E), .source_reg2_E(source_reg2_E),
    .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E),
    .imm_E(imm_E), .op_a_E(op_a_E), .op_b_E(op_b_E)
`ifdef DE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_D = 1'b0; flush_D = 1'b0;
    forward_A = FWD_NONE; forward_B = FWD_NONE;
    valid_D = 1'b1; opcode_D = 5'h0A; rd_D = 3'd6;
    source_reg1_D = 3'd0; source_reg2_D = 3'd0;
    rs1_data_D = 16'h5555; rs2_data_D = 16'h6666; imm_D = 16'h7777;
    reg_write_D = 1'b1; mem_read_D = 1'b1; mem_write_D = 1'b1;
    rd_W = 3'd0; reg_write_W = 1'b0; result_W = 16'h0;

    // T1 reset overrides a valid decode slot
    step();
    chk("rst_valid",  {15'd0, valid_E},     16'd0);
    chk("rst_opcode", {11'd0, opcode_E},    16'd0);
    chk("rst_rw",     {15'd0, reg_write_E}, 16'd0);
    chk("rst_rd",     {13'd0, rd_E},        16'd0);
    chk("rst_op_a",   op_a_E,               16'h0000);

    // T2 plain load, no WB match
    rst = 1'b0; opcode_D = 5'h03; rd_D = 3'd2; source_reg1_D = 3'd1; source_reg2_D = 3'd3;
    rs1_data_D = 16'h1234; rs2_data_D = 16'h5678; imm_D = 16'h00AB;
    reg_write_D = 1'b1; mem_read_D = 1'b1; mem_write_D = 1'b0;
    step();
    chk("ld_opcode", {11'd0, opcode_E},      16'h0003);
    chk("ld_rd",     {13'd0, rd_E},          16'd2);
    chk("ld_op_a",   op_a_E,                 16'h1234);
    chk("ld_op_b",   op_b_E,                 16'h5678);
    chk("ld_imm",    imm_E,                  16'h00AB);
    chk("ld_valid",  {15'd0, valid_E},       16'd1);
    chk("ld_mrd",    {15'd0, mem_read_E},    16'd1);
    chk("ld_mwr",    {15'd0, mem_write_E},   16'd0);
    chk("ld_src1",   {13'd0, source_reg1_E}, 16'd1);

    // T3 stall+flush together -> bubble, operands and imm kept
    stall_D = 1'b1; flush_D = 1'b1;
    step();
    chk("bub_valid",  {15'd0, valid_E},     16'd0);
    chk("bub_rw",     {15'd0, reg_write_E}, 16'd0);
    chk("bub_opcode", {11'd0, opcode_E},    16'd0);
    chk("bub_rd",     {13'd0, rd_E},        16'd0);
    chk("bub_mrd",    {15'd0, mem_read_E},  16'd0);
    chk("bub_op_a",   op_a_E,               16'h1234);
    chk("bub_imm",    imm_E,                16'h00AB);

    // stall alone for 3 cycles with changing D inputs; WB to r0 must not refresh an invalid slot
    flush_D = 1'b0; opcode_D = 5'h1F; rd_D = 3'd7; rs1_data_D = 16'h9999; imm_D = 16'hCCCC;
    reg_write_W = 1'b1; rd_W = 3'd0; result_W = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_opcode", {11'd0, opcode_E}, 16'd0);
      chk("hold_valid",  {15'd0, valid_E},  16'd0);
    end
    reg_write_W = 1'b0; result_W = 16'h0;
    chk("hold_op_a", op_a_E, 16'h1234);
    chk("hold_imm",  imm_E,  16'h00AB);

    // T4 load src1=4, then stall while WB writes r4
    stall_D = 1'b0; opcode_D = 5'h04; rd_D = 3'd7; source_reg1_D = 3'd4; source_reg2_D = 3'd6;
    rs1_data_D = 16'h4444; rs2_data_D = 16'h6666; imm_D = 16'h0010;
    step();
    chk("t4_op_a", op_a_E, 16'h4444);
    chk("t4_src1", {13'd0, source_reg1_E}, 16'd4);
    stall_D = 1'b1; reg_write_W = 1'b1; rd_W = 3'd4; result_W = 16'hBEEF; rs1_data_D = 16'h9999;
    step();
    reg_write_W = 1'b0; result_W = 16'h0;
    #1;
    chk("refresh_op_a", op_a_E, 16'hBEEF);
    chk("refresh_op_b", op_b_E, 16'h6666);
    chk("refresh_opc",  {11'd0, opcode_E}, 16'h0004);

    // T5 combinational forwarding, including reserved encodings
    result_W = 16'h00FF; forward_B = 2'b10;
    #1; chk("fwd_b_wb",  op_b_E, 16'h00FF);
    forward_B = 2'b01;
    #1; chk("fwd_b_01",  op_b_E, 16'h6666);
    forward_B = 2'b11;
    #1; chk("fwd_b_11",  op_b_E, 16'h6666);
    forward_A = 2'b10;
    #1; chk("fwd_a_wb",  op_a_E, 16'h00FF);
    forward_A = FWD_NONE; forward_B = FWD_NONE;

    // T6 load-time bypass on source 2 only
    stall_D = 1'b0; source_reg1_D = 3'd1; source_reg2_D = 3'd5;
    rs1_data_D = 16'hAAAA; rs2_data_D = 16'h1111;
    reg_write_W = 1'b1; rd_W = 3'd5; result_W = 16'h2222;
    step();
    reg_write_W = 1'b0; result_W = 16'h0;
    #1;
    chk("byp_op_b", op_b_E, 16'h2222);
    chk("byp_op_a", op_a_E, 16'hAAAA);

`ifdef DE_PERF_CNT_EN
    chk("stall_cnt",  stall_cnt,  16'd4);
    chk("bubble_cnt", bubble_cnt, 16'd1);
    rst = 1'b1;
    step();
    chk("cnt_rst_s", stall_cnt,  16'd0);
    chk("cnt_rst_b", bubble_cnt, 16'd0);
`else
    rst = 1'b1;
    step();
`endif
    chk("final_rst_valid", {15'd0, valid_E}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
